// File: rtl/icache_stream_prefetch_pkg.sv
// Shared types for the sequential instruction-stream prefetcher: bus command codes
// and the outstanding-request slot record.
package icache_stream_prefetch_pkg;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_LOAD = 2'b01;

  // Slot line field is sized for the widest supported address; narrower builds zero-extend.
  localparam int PF_MAX_XLEN = 64;
  localparam int PF_LINE_W   = PF_MAX_XLEN - 3;

  typedef logic [PF_LINE_W-1:0] pf_line_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] mem_tag;
    pf_line_t   line;
  } pf_slot_t;

  function automatic pf_slot_t pf_slot_load(input logic [3:0] tag, input pf_line_t line);
    pf_slot_t s;
    s.valid   = 1'b1;
    s.mem_tag = tag;
    s.line    = line;
    return s;
  endfunction

endpackage

// File: rtl/pf_slot_alloc.sv
// Priority free-slot finder: lowest-index free slot wins, one-hot grant plus found flag.
// Purely combinational; no backpressure of its own.
module pf_slot_alloc #(
  parameter int N = 4
) (
  input  logic [N-1:0] free_i,
  output logic [N-1:0] grant_o,
  output logic         found_o
);

  always_comb begin
    logic hit;
    hit     = 1'b0;
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      if (free_i[i] && !hit) begin
        grant_o[i] = 1'b1;
        hit        = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/icache_stream_prefetch.sv
// Next-line instruction prefetcher: issues up to LOOKAHEAD lines ahead of demand, tracks
// in-flight requests in slots; bus command and fill write are same-cycle combinational.
module icache_stream_prefetch
  import icache_stream_prefetch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PREF_DEPTH = 4,
  parameter int LOOKAHEAD  = 4,
  parameter int IDX_BITS   = 5,
  parameter int TAG_BITS   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pf_enable,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_addr,
  input  logic                demand_advance,
  input  logic                give_way,
  input  logic                lookup_valid,
  input  logic [XLEN-1:0]     lookup_addr,
  output logic                already_fetched,
  input  logic [3:0]          Imem2pref_response,
  input  logic [3:0]          Imem2pref_tag,
  output logic [1:0]          prefetch_command,
  output logic [XLEN-1:0]     prefetch_addr,
  output logic                prefetch_wr_enable,
  output logic [IDX_BITS-1:0] prefetch_index,
  output logic [TAG_BITS-1:0] prefetch_tag
);

  localparam int         LW       = XLEN - 3;
  localparam logic [7:0] LA_LIMIT = 8'(LOOKAHEAD);

  pf_slot_t        slots_q [PREF_DEPTH];
  pf_slot_t        slots_d [PREF_DEPTH];
  logic [LW-1:0]   next_line_q, next_line_d;
  logic [7:0]      ahead_q, ahead_d;

  logic [PREF_DEPTH-1:0] free_vec;
  logic [PREF_DEPTH-1:0] dup_vec;
  logic [PREF_DEPTH-1:0] look_vec;
  logic [PREF_DEPTH-1:0] cpl_vec;
  logic [PREF_DEPTH-1:0] grant;
  logic                  found;

  logic     cpl_fire;
  pf_line_t cpl_line;
  logic     base_ok, issue_ok, skip, accept, step;
  logic     unused_bits;

  always_comb begin
    for (int i = 0; i < PREF_DEPTH; i++) begin
      free_vec[i] = ~slots_q[i].valid;
      dup_vec[i]  = slots_q[i].valid && (slots_q[i].line == pf_line_t'(next_line_q));
      look_vec[i] = slots_q[i].valid && (slots_q[i].line == pf_line_t'(lookup_addr[XLEN-1:3]));
    end
  end

  // A slot retiring this cycle still reads as valid here, so it cannot be re-granted until next cycle.
  pf_slot_alloc #(
    .N (PREF_DEPTH)
  ) u_alloc (
    .free_i  (free_vec),
    .grant_o (grant),
    .found_o (found)
  );

  always_comb begin
    cpl_fire = 1'b0;
    cpl_vec  = '0;
    cpl_line = '0;
    for (int i = 0; i < PREF_DEPTH; i++) begin
      if (!cpl_fire && (Imem2pref_tag != 4'd0) && slots_q[i].valid &&
          (slots_q[i].mem_tag == Imem2pref_tag)) begin
        cpl_fire   = 1'b1;
        cpl_vec[i] = 1'b1;
        cpl_line   = slots_q[i].line;
      end
    end
  end

  assign base_ok  = ~reset & pf_enable & ~redirect & ~give_way & (ahead_q < LA_LIMIT);
  assign issue_ok = base_ok & found & ~|dup_vec;
  assign skip     = base_ok & |dup_vec;
  assign accept   = issue_ok & (Imem2pref_response != 4'd0);
  assign step     = accept | skip;

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < PREF_DEPTH; i++) begin
      if (cpl_vec[i]) begin
        slots_d[i] = '0;
      end else if (accept && grant[i]) begin
        slots_d[i] = pf_slot_load(Imem2pref_response, pf_line_t'(next_line_q));
      end
    end
  end

  always_comb begin
    next_line_d = next_line_q;
    if (redirect) begin
      next_line_d = redirect_addr[XLEN-1:3] + LW'(1);
    end else if (step) begin
      next_line_d = next_line_q + LW'(1);
    end
  end

  // An issue and a consumed line in the same cycle cancel out.
  always_comb begin
    ahead_d = ahead_q;
    if (redirect) begin
      ahead_d = '0;
    end else if (step && !demand_advance) begin
      ahead_d = ahead_q + 8'd1;
    end else if (!step && demand_advance && (ahead_q != 8'd0)) begin
      ahead_d = ahead_q - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      next_line_q <= '0;
      ahead_q     <= '0;
      for (int i = 0; i < PREF_DEPTH; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      next_line_q <= next_line_d;
      ahead_q     <= ahead_d;
      slots_q     <= slots_d;
    end
  end

  assign prefetch_command   = issue_ok ? BUS_LOAD : BUS_NONE;
  assign prefetch_addr      = {next_line_q, 3'b000};
  assign prefetch_wr_enable = cpl_fire & ~reset;
  assign prefetch_index     = cpl_line[IDX_BITS-1:0];
  assign prefetch_tag       = cpl_line[IDX_BITS+TAG_BITS-1:IDX_BITS];
  assign already_fetched    = lookup_valid & ~reset & |look_vec;

  assign unused_bits = ^{lookup_addr[2:0], redirect_addr[2:0],
                         cpl_line[PF_LINE_W-1:IDX_BITS+TAG_BITS]};

endmodule
